// File: rtl/freelist.sv
// Physical-register free list for rename: hands out up to RENAME_WIDTH prds per
// cycle from head, reclaims committed prev_rd at tail, and checkpoints head per branch.
module freelist #(
    parameter int RENAME_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int PRF_SIZE     = 64,
    parameter int ARF_SIZE     = 32,
    parameter int CP_SIZE      = 4,
    localparam int PRF_W       = $clog2(PRF_SIZE),
    localparam int CP_W        = $clog2(CP_SIZE)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [RENAME_WIDTH-1:0]                  alloc_req,
    output logic [RENAME_WIDTH-1:0][PRF_W-1:0]       alloc_prd,
    output logic                                     alloc_gnt,
    output logic                                     allocatable,
    input  logic [COMMIT_WIDTH-1:0]                  release_valid,
    input  logic [COMMIT_WIDTH-1:0][PRF_W-1:0]       release_prf,
    input  logic                                     check,
    input  logic [CP_W-1:0]                          check_idx,
    input  logic                                     recover,
    input  logic [CP_W-1:0]                          recover_idx,
    output logic [PRF_W:0]                           free_count,
    output logic                                     ready
);
    typedef logic [PRF_W:0] ptr_t;

    logic [PRF_W-1:0]        entries [PRF_SIZE];
    ptr_t                    head, tail, head_next;
    ptr_t                    cp [CP_SIZE];
    ptr_t                    n_req, n_rel;
    logic [PRF_W-1:0]        rel_slot [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] rel_en;
    logic                    gnt;

    assign free_count  = tail - head;
    assign allocatable = free_count >= ptr_t'(RENAME_WIDTH);
    assign alloc_gnt   = gnt;
    assign head_next   = gnt ? head + n_req : head;

    // The k-th requesting slot takes entry[head+k]; grant is all-or-nothing.
    always_comb begin
        n_req     = '0;
        alloc_prd = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (alloc_req[i]) begin
                alloc_prd[i] = entries[PRF_W'(head + n_req)];
                n_req        = n_req + ptr_t'(1);
            end
        end
        gnt = !reset && !recover && (n_req <= free_count);
        if (!gnt) alloc_prd = '0;
    end

    // Releases of p0 are dropped; the rest are packed at tail in slot order.
    always_comb begin
        n_rel = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rel_en[i]   = release_valid[i] && (release_prf[i] != '0);
            rel_slot[i] = PRF_W'(tail + n_rel);
            if (rel_en[i]) n_rel = n_rel + ptr_t'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PRF_SIZE; i++)
                entries[i] <= (i < PRF_SIZE - ARF_SIZE) ? PRF_W'(ARF_SIZE + i) : '0;
            for (int i = 0; i < CP_SIZE; i++)
                cp[i] <= '0;
            head  <= '0;
            tail  <= ptr_t'(PRF_SIZE - ARF_SIZE);
            ready <= 1'b0;
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (rel_en[i]) entries[rel_slot[i]] <= release_prf[i];
            tail  <= tail + n_rel;
            ready <= 1'b1;
            // Recover wins over a same-cycle checkpoint write.
            if (recover) begin
                head <= cp[recover_idx];
            end else begin
                head <= head_next;
                if (check) cp[check_idx] <= head_next;
            end
        end
    end
endmodule
